// File: rtl/luffa_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : luffa_msg_padder
// Brief    : 32-bit host word stream to Luffa 16-bit load/fetch protocol with
//            1-then-zeros padding to a 256-bit block and digest assembly.
// Revision : 1.0 - initial release
// ============================================================================
module luffa_msg_padder #(
   parameter int BLK_HW = 16,
   parameter int DIG_HW = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [31:0]           s_data,
   input  logic [2:0]            s_bytes,
   input  logic                  s_last,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  luffa_init,
   output logic                  luffa_load,
   output logic                  luffa_fetch,
   output logic [15:0]           luffa_idata,
   input  logic                  luffa_ack,
   input  logic [15:0]           luffa_odata,
   output logic                  busy,
   output logic [DIG_HW*16-1:0]  digest,
   output logic                  digest_valid
);

   localparam int HW_W = $clog2(BLK_HW);
   localparam int DC_W = $clog2(DIG_HW);
   localparam logic [HW_W-1:0] c_hw_last  = HW_W'(BLK_HW - 1);
   localparam logic [DC_W-1:0] c_dig_last = DC_W'(DIG_HW - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_INIT  = 4'd1,
      S_WAIT  = 4'd2,
      S_HI    = 4'd3,
      S_LO    = 4'd4,
      S_MARK  = 4'd5,
      S_PAD   = 4'd6,
      S_FETCH = 4'd7
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [31:0]           r_word;
   logic                  r_last;
   logic [2:0]            r_bytes;
   logic [HW_W-1:0]       r_hw_cnt;
   logic [DC_W-1:0]       r_dig_cnt;
   logic [DIG_HW*16-1:0]  r_digest;
   logic                  r_digest_valid;

   logic        w_ready;
   logic        w_init;
   logic        w_load;
   logic        w_fetch;
   logic [15:0] w_idata;
   logic [15:0] w_hi;
   logic [15:0] w_lo;

   // Final-word substitution: the 0x80 marker lands right after the last valid byte
   always_comb begin
      w_hi = r_word[31:16];
      w_lo = r_word[15:0];
      if (r_last) begin
         case (r_bytes)
            3'd0: begin
               w_hi = 16'h8000;
               w_lo = 16'h0000;
            end
            3'd1: begin
               w_hi = {r_word[31:24], 8'h80};
               w_lo = 16'h0000;
            end
            3'd2: w_lo = 16'h8000;
            3'd3: w_lo = {r_word[15:8], 8'h80};
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_init  = 1'b0;
      w_load  = 1'b0;
      w_fetch = 1'b0;
      w_idata = 16'h0000;
      case (r_state)
         S_IDLE: if (start) w_next = S_INIT;
         S_INIT: begin
            w_init = 1'b1;
            w_next = S_WAIT;
         end
         S_WAIT: begin
            w_ready = 1'b1;
            if (s_valid) w_next = S_HI;
         end
         S_HI: begin
            w_load  = 1'b1;
            w_idata = w_hi;
            if (luffa_ack) w_next = S_LO;
         end
         S_LO: begin
            w_load  = 1'b1;
            w_idata = w_lo;
            if (luffa_ack) begin
               if (!r_last)         w_next = S_WAIT;
               else if (r_bytes[2]) w_next = S_MARK;
               else                 w_next = S_PAD;
            end
         end
         S_MARK: begin
            w_load  = 1'b1;
            w_idata = 16'h8000;
            if (luffa_ack) w_next = S_PAD;
         end
         // Block is complete once the counter sits at zero; no request in that cycle
         S_PAD: begin
            if (r_hw_cnt == '0) w_next = S_FETCH;
            else                w_load = 1'b1;
         end
         S_FETCH: begin
            w_fetch = 1'b1;
            if (luffa_ack && (r_dig_cnt == c_dig_last)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_word         <= '0;
         r_last         <= 1'b0;
         r_bytes        <= '0;
         r_hw_cnt       <= '0;
         r_dig_cnt      <= '0;
         r_digest       <= '0;
         r_digest_valid <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_digest_valid <= 1'b0;
         if (r_state == S_INIT) begin
            r_hw_cnt  <= '0;
            r_dig_cnt <= '0;
         end
         if (w_ready && s_valid) begin
            r_word  <= s_data;
            r_last  <= s_last;
            r_bytes <= s_bytes;
         end
         if (w_load && luffa_ack)
            r_hw_cnt <= (r_hw_cnt == c_hw_last) ? '0 : r_hw_cnt + HW_W'(1);
         if (w_fetch && luffa_ack) begin
            r_digest <= {r_digest[DIG_HW*16-17:0], luffa_odata};
            if (r_dig_cnt == c_dig_last) begin
               r_dig_cnt      <= '0;
               r_digest_valid <= 1'b1;
            end else begin
               r_dig_cnt <= r_dig_cnt + DC_W'(1);
            end
         end
      end
   end

   assign s_ready      = w_ready;
   assign luffa_init   = w_init;
   assign luffa_load   = w_load;
   assign luffa_fetch  = w_fetch;
   assign luffa_idata  = w_idata;
   assign busy         = (r_state != S_IDLE);
   assign digest       = r_digest;
   assign digest_valid = r_digest_valid;

endmodule
`default_nettype wire

// File: tb/tb_luffa_msg_padder.sv
`default_nettype none
// Directed bench for luffa_msg_padder with a Luffa-side responder that
// acknowledges after optional random stalls and records every load.
module tb_luffa_msg_padder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [31:0]  s_data = '0;
   logic [2:0]   s_bytes = '0;
   logic         s_last = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic         luffa_init;
   logic         luffa_load;
   logic         luffa_fetch;
   logic [15:0]  luffa_idata;
   logic         luffa_ack = 1'b0;
   logic [15:0]  luffa_odata = '0;
   logic         busy;
   logic [255:0] digest;
   logic         digest_valid;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] load_q[$];
   logic [15:0] exp_q[$];
   int          fetch_n = 0, init_cnt = 0, dv_cnt = 0, stab_err = 0, excl_err = 0;
   int          stall = 0, stall_en = 0;
   logic [15:0] odata_base = '0;
   logic        p_load = 1'b0, p_fetch = 1'b0, p_ack = 1'b0;
   logic [15:0] p_idata = '0;

   luffa_msg_padder #(.BLK_HW(16), .DIG_HW(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .s_data       (s_data),
      .s_bytes      (s_bytes),
      .s_last       (s_last),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .luffa_init   (luffa_init),
      .luffa_load   (luffa_load),
      .luffa_fetch  (luffa_fetch),
      .luffa_idata  (luffa_idata),
      .luffa_ack    (luffa_ack),
      .luffa_odata  (luffa_odata),
      .busy         (busy),
      .digest       (digest),
      .digest_valid (digest_valid)
   );

   always #5 clk = ~clk;

   // Luffa-side responder and protocol monitor, active on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (p_ack && (p_load || p_fetch)) begin
               if (p_load)  load_q.push_back(p_idata);
               if (p_fetch) fetch_n++;
               stall = (stall_en != 0) ? int'($urandom_range(0, 5)) : 0;
            end else if (p_load || p_fetch) begin
               if (luffa_load !== p_load || luffa_fetch !== p_fetch || luffa_idata !== p_idata)
                  stab_err++;
            end
            if (int'(luffa_init) + int'(luffa_load) + int'(luffa_fetch) > 1) excl_err++;
            if (luffa_init)   init_cnt++;
            if (digest_valid) dv_cnt++;
            if (luffa_load || luffa_fetch) begin
               if (stall > 0) begin
                  stall--;
                  luffa_ack = 1'b0;
               end else begin
                  luffa_ack = 1'b1;
               end
            end else begin
               luffa_ack = 1'b0;
            end
            luffa_odata = odata_base + 16'(fetch_n + 1);
         end else begin
            luffa_ack = 1'b0;
            stall     = 0;
         end
         p_load  = luffa_load;
         p_fetch = luffa_fetch;
         p_idata = luffa_idata;
         p_ack   = luffa_ack;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1);
   end

   function automatic logic [255:0] exp_digest(input logic [15:0] base);
      logic [255:0] d = '0;
      for (int i = 1; i <= 16; i++) d = {d[239:0], base + 16'(i)};
      return d;
   endfunction

   // Index of the first disagreement between recorded and expected loads, -1 if none
   function automatic int first_bad();
      int n = (load_q.size() < exp_q.size()) ? load_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (load_q[i] !== exp_q[i]) return i;
      if (load_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic pad_exp(input int n);
      while (exp_q.size() < n) exp_q.push_back(16'h0000);
   endtask

   task automatic start_msg();
      @(negedge clk);
      load_q.delete();
      exp_q.delete();
      fetch_n = 0; init_cnt = 0; dv_cnt = 0; stab_err = 0; excl_err = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
      int t = 0;
      while (!s_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         n_checks++;
         $display("FAIL send_word_timeout: s_ready=%b required 1", s_ready);
      end
      s_data = d; s_bytes = b; s_last = l; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_digest();
      int t = 0;
      while (!digest_valid && t < 3000) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!digest_valid) $display("FAIL digest_timeout: digest_valid=%b required 1", digest_valid);
      else n_pass++;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_loads(input string name);
      int b = first_bad();
      n_checks++;
      if (b >= 0)
         $display("FAIL %s: at index %0d got %h (%0d loads) required %h (%0d loads)", name, b,
                  (b < load_q.size()) ? load_q[b] : 16'hxxxx, load_q.size(),
                  (b < exp_q.size()) ? exp_q[b] : 16'hxxxx, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b required 0", s_ready); else n_pass++;
      n_checks++;
      if ({luffa_init, luffa_load, luffa_fetch} !== 3'b000)
         $display("FAIL reset_requests: got %b required 000", {luffa_init, luffa_load, luffa_fetch});
      else n_pass++;
      n_checks++; if (luffa_idata !== 16'h0) $display("FAIL reset_idata: got %h required 0000", luffa_idata); else n_pass++;
      n_checks++; if (digest !== 256'h0) $display("FAIL reset_digest: got %h required 0", digest); else n_pass++;
      n_checks++; if (digest_valid !== 1'b0) $display("FAIL reset_digest_valid: got %b required 0", digest_valid); else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_empty();
      stall_en = 0; odata_base = 16'h0000;
      start_msg();
      send_word(32'h0, 3'd0, 1'b1);
      wait_digest();
      exp_q.push_back(16'h8000); pad_exp(16);
      check_loads("empty_loads");
      n_checks++; if (digest !== exp_digest(16'h0000)) $display("FAIL empty_digest: got %h required %h", digest, exp_digest(16'h0000)); else n_pass++;
      n_checks++; if (dv_cnt !== 1) $display("FAIL empty_dv_pulses: got %0d required 1", dv_cnt); else n_pass++;
      n_checks++; if (init_cnt !== 1) $display("FAIL empty_init_pulses: got %0d required 1", init_cnt); else n_pass++;
      n_checks++; if (excl_err !== 0) $display("FAIL empty_exclusive: got %0d overlaps required 0", excl_err); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL empty_busy_after: got %b required 0", busy); else n_pass++;
   endtask

   task automatic test_abc();
      stall_en = 0; odata_base = 16'h0000;
      start_msg();
      send_word(32'h61626300, 3'd3, 1'b1);
      wait_digest();
      exp_q.push_back(16'h6162); exp_q.push_back(16'h6380); pad_exp(16);
      check_loads("abc_loads");
      n_checks++; if (dv_cnt !== 1) $display("FAIL abc_dv_pulses: got %0d required 1", dv_cnt); else n_pass++;
   endtask

   task automatic test_full_block();
      stall_en = 0; odata_base = 16'h0100;
      start_msg();
      for (int k = 0; k < 8; k++) begin
         send_word({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, 3'd4, 1'b0 | (k == 7));
         exp_q.push_back({8'(4*k), 8'(4*k+1)});
         exp_q.push_back({8'(4*k+2), 8'(4*k+3)});
      end
      wait_digest();
      exp_q.push_back(16'h8000); pad_exp(32);
      check_loads("block256_loads");
      n_checks++; if (digest !== exp_digest(16'h0100)) $display("FAIL block256_digest: got %h required %h", digest, exp_digest(16'h0100)); else n_pass++;
      n_checks++; if (dv_cnt !== 1) $display("FAIL block256_dv_pulses: got %0d required 1", dv_cnt); else n_pass++;
   endtask

   task automatic test_stall();
      stall_en = 1; odata_base = 16'h0000;
      start_msg();
      n_checks++; if (digest !== exp_digest(16'h0100)) $display("FAIL stall_digest_held: got %h required %h", digest, exp_digest(16'h0100)); else n_pass++;
      send_word(32'hDEADBEEF, 3'd0, 1'b0);
      send_word(32'hA5123456, 3'd1, 1'b1);
      wait_digest();
      exp_q.push_back(16'hDEAD); exp_q.push_back(16'hBEEF);
      exp_q.push_back(16'hA580); pad_exp(16);
      check_loads("stall_loads");
      n_checks++; if (stab_err !== 0) $display("FAIL stall_stability: got %0d changes required 0", stab_err); else n_pass++;
      n_checks++; if (digest !== exp_digest(16'h0000)) $display("FAIL stall_digest: got %h required %h", digest, exp_digest(16'h0000)); else n_pass++;
   endtask

   task automatic test_start_busy();
      int t;
      stall_en = 1; odata_base = 16'h0000;
      start_msg();
      start = 1'b1; @(negedge clk); start = 1'b0;
      send_word(32'h61626300, 3'd7, 1'b1);
      t = 0;
      while (!luffa_fetch && t < 1000) begin @(negedge clk); t++; end
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_digest();
      exp_q.push_back(16'h6162); exp_q.push_back(16'h6300);
      exp_q.push_back(16'h8000); pad_exp(16);
      check_loads("busy_start_loads");
      n_checks++; if (init_cnt !== 1) $display("FAIL busy_start_init: got %0d required 1", init_cnt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL busy_start_idle: got %b required 0", busy); else n_pass++;
      n_checks++; if (stab_err !== 0) $display("FAIL busy_start_stability: got %0d required 0", stab_err); else n_pass++;
   endtask

   task automatic test_reset_pad();
      int t = 0;
      stall_en = 0; odata_base = 16'h0000;
      start_msg();
      send_word(32'h61626300, 3'd3, 1'b1);
      while (load_q.size() < 4 && t < 1000) begin @(negedge clk); t++; end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstpad_busy: got %b required 0", busy); else n_pass++;
      n_checks++; if (luffa_load !== 1'b0) $display("FAIL rstpad_load: got %b required 0", luffa_load); else n_pass++;
      n_checks++; if (luffa_idata !== 16'h0) $display("FAIL rstpad_idata: got %h required 0000", luffa_idata); else n_pass++;
      n_checks++; if (digest !== 256'h0) $display("FAIL rstpad_digest: got %h required 0", digest); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start_msg();
      send_word(32'h0, 3'd0, 1'b1);
      wait_digest();
      exp_q.push_back(16'h8000); pad_exp(16);
      n_checks++; if (init_cnt !== 1) $display("FAIL rstpad_reinit: got %0d required 1", init_cnt); else n_pass++;
      check_loads("rstpad_loads");
   endtask

   initial begin
      test_reset();
      test_empty();
      test_abc();
      test_full_block();
      test_stall();
      test_start_busy();
      test_reset_pad();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
